vga_timing_generator: RTL and testbench

- Produces the 640x480@60 Hz VGA raster: horizontal/vertical pixel counters feeding colour generation, plus HSYNC/VSYNC sent to the connector.
- Sync outputs are delayed by a programmable number of cycles so they line up with the registered, sprite-RAM-latency colour path.
- Also emits line, vertical-blank and game-tick strobes; game logic uses the game tick to update player and car positions.

---
 rtl/vga_timing_generator.sv | 148 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// 640x480@60 Hz VGA raster timing: pixel/line counters, active flag, delayed
// HSYNC/VSYNC, and line / vertical-blank / game-tick strobes.
// Every flag is registered from the next counter values, so it is aligned
// with the counts it describes.
module vga_timing_generator #(
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 2,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [9:0] o_h_count,
    output logic [9:0] o_v_count,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_vblank_start,
    output logic       o_game_tick
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
    localparam logic [9:0] HDisp      = 10'(H_DISPLAY);
    localparam logic [9:0] VDisp      = 10'(V_DISPLAY);
    localparam logic [9:0] HSyncFirst = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HSyncLast  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VSyncFirst = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VSyncLast  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [7:0] TickLast   = 8'(TICK_DIV - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       active_q, active_d;
    logic       line_start_q, line_start_d;
    logic       vblank_q, vblank_d;
    logic       tick_q, tick_d;
    logic [7:0] div_q, div_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;

    // Free-running raster counters; v advances only when h wraps.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
        end
    end

    // Flags decoded from the next counts so they land on the same edge as the counts.
    always_comb begin
        active_d     = (h_d < HDisp) && (v_d < VDisp);
        line_start_d = (h_d == '0);
        vblank_d     = (h_d == '0) && (v_d == VDisp);
        hs_raw_d     = !((h_d >= HSyncFirst) && (h_d <= HSyncLast));
        vs_raw_d     = !((v_d >= VSyncFirst) && (v_d <= VSyncLast));
    end

    // Game-tick divider: count vblanks, fire and clear on the TICK_DIV-th one.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (vblank_d) begin
            if (div_q == TickLast) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    // State and registered outputs; reset leaves the raster parked at (0,0).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q          <= '0;
            v_q          <= '0;
            active_q     <= 1'b1;
            line_start_q <= 1'b0;
            vblank_q     <= 1'b0;
            tick_q       <= 1'b0;
            div_q        <= '0;
            hs_raw_q     <= 1'b1;
            vs_raw_q     <= 1'b1;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            active_q     <= active_d;
            line_start_q <= line_start_d;
            vblank_q     <= vblank_d;
            tick_q       <= tick_d;
            div_q        <= div_d;
            hs_raw_q     <= hs_raw_d;
            vs_raw_q     <= vs_raw_d;
        end
    end

    // Sync delay line matching the colour pipeline latency.
    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign o_hsync = hs_raw_q;
            assign o_vsync = vs_raw_q;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
            logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;

            // Shift the aligned raw syncs in at bit 0; the oldest sample leaves the top.
            always_comb begin
                hs_dly_d = (hs_dly_q << 1) | SYNC_DELAY'(hs_raw_q);
                vs_dly_d = (vs_dly_q << 1) | SYNC_DELAY'(vs_raw_q);
            end

            // Delay stages idle high (sync inactive) through reset.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    hs_dly_q <= '1;
                    vs_dly_q <= '1;
                end else begin
                    hs_dly_q <= hs_dly_d;
                    vs_dly_q <= vs_dly_d;
                end
            end

            assign o_hsync = hs_dly_q[SYNC_DELAY-1];
            assign o_vsync = vs_dly_q[SYNC_DELAY-1];
        end
    endgenerate

    assign o_h_count      = h_q;
    assign o_v_count      = v_q;
    assign o_active       = active_q;
    assign o_line_start   = line_start_q;
    assign o_vblank_start = vblank_q;
    assign o_game_tick    = tick_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: one full-size raster (SYNC_DELAY=2) and two
// shrunken rasters (SYNC_DELAY 0 and 7, TICK_DIV 3 and 2) run side by side
// against an arithmetic model of time-since-reset.
module tb_vga_timing_generator;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       act;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       vb;
        logic       gt;
    } out_t;

    typedef struct packed {
        int hd; int hf; int hsw; int hb;
        int vd; int vf; int vsw; int vb;
        int sd; int td;
    } cfg_t;

    typedef struct {
        int         t;
        int         sel;
        logic [9:0] h;
        logic [9:0] v;
        logic       act, hs, vs, ls, vb, gt;
    } vec_t;

    // Shrunken raster so several whole frames fit in a short run.
    localparam int SHD = 20, SHF = 4, SHS = 6, SHB = 5;
    localparam int SVD = 12, SVF = 3, SVS = 2, SVB = 4;
    localparam int SHT = SHD + SHF + SHS + SHB;  // 35
    localparam int SVT = SVD + SVF + SVS + SVB;  // 21
    localparam int SFT = SHT * SVT;              // 735

    localparam cfg_t CFG_F  = '{hd: 640, hf: 16, hsw: 96, hb: 48, vd: 480, vf: 10, vsw: 2,
                                vb: 33, sd: 2, td: 1};
    localparam cfg_t CFG_S0 = '{hd: SHD, hf: SHF, hsw: SHS, hb: SHB, vd: SVD, vf: SVF,
                                vsw: SVS, vb: SVB, sd: 0, td: 3};
    localparam cfg_t CFG_S7 = '{hd: SHD, hf: SHF, hsw: SHS, hb: SHB, vd: SVD, vf: SVF,
                                vsw: SVS, vb: SVB, sd: 7, td: 2};

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [9:0] f_h, f_v, s0_h, s0_v, s7_h, s7_v;
    logic f_act, f_hs, f_vs, f_ls, f_vb, f_gt;
    logic s0_act, s0_hs, s0_vs, s0_ls, s0_vb, s0_gt;
    logic s7_act, s7_hs, s7_vs, s7_ls, s7_vb, s7_gt;
    out_t f_o, s0_o, s7_o;

    assign f_o  = {f_h, f_v, f_act, f_hs, f_vs, f_ls, f_vb, f_gt};
    assign s0_o = {s0_h, s0_v, s0_act, s0_hs, s0_vs, s0_ls, s0_vb, s0_gt};
    assign s7_o = {s7_h, s7_v, s7_act, s7_hs, s7_vs, s7_ls, s7_vb, s7_gt};

    always #5 clk = ~clk;

    vga_timing_generator u_full (
        .CLK(clk), .RST_N(rst_n), .o_h_count(f_h), .o_v_count(f_v), .o_active(f_act),
        .o_hsync(f_hs), .o_vsync(f_vs), .o_line_start(f_ls), .o_vblank_start(f_vb),
        .o_game_tick(f_gt)
    );

    vga_timing_generator #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_DELAY(0), .TICK_DIV(3)
    ) u_small0 (
        .CLK(clk), .RST_N(rst_n), .o_h_count(s0_h), .o_v_count(s0_v), .o_active(s0_act),
        .o_hsync(s0_hs), .o_vsync(s0_vs), .o_line_start(s0_ls), .o_vblank_start(s0_vb),
        .o_game_tick(s0_gt)
    );

    vga_timing_generator #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_DELAY(7), .TICK_DIV(2)
    ) u_small7 (
        .CLK(clk), .RST_N(rst_n), .o_h_count(s7_h), .o_v_count(s7_v), .o_active(s7_act),
        .o_hsync(s7_hs), .o_vsync(s7_vs), .o_line_start(s7_ls), .o_vblank_start(s7_vb),
        .o_game_tick(s7_gt)
    );

    // Expected outputs t clock edges after reset release, from raster arithmetic.
    function automatic out_t model(input int t, input cfg_t c);
        out_t o;
        int ht, vt, ft, p, hp, vp, n;
        ht   = c.hd + c.hf + c.hsw + c.hb;
        vt   = c.vd + c.vf + c.vsw + c.vb;
        ft   = ht * vt;
        p    = t % ft;
        o.h  = 10'(p % ht);
        o.v  = 10'(p / ht);
        o.act = (p % ht < c.hd) && (p / ht < c.vd);
        o.ls = (t > 0) && (p % ht == 0);
        o.vb = (t > 0) && (p == c.vd * ht);
        n    = (t - c.vd * ht) / ft + 1;  // ordinal of this vblank since release
        o.gt = o.vb && (n % c.td == 0);
        if (t < c.sd) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
        end else begin
            hp   = (t - c.sd) % ht;
            vp   = ((t - c.sd) % ft) / ht;
            o.hs = !(hp >= c.hd + c.hf && hp < c.hd + c.hf + c.hsw);
            o.vs = !(vp >= c.vd + c.vf && vp < c.vd + c.vf + c.vsw);
        end
        return o;
    endfunction

    task automatic check_out(input string name, input out_t a, input out_t e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h (h,v,act,hs,vs,ls,vb,gt)",
                     name, cyc, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, a, e);
        end
    endtask

    task automatic wait_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc != t && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) check_int("wait_cyc_timeout", cyc, t);
    endtask

    // Count/position statistics, restarted by every reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int f_hs_low, f_ls_n, f_act_n, f_bad_act;
    int s0_act_n, s0_vs_low, s0_tick7, s0_vb7, s0_tick2, s0_tick3, s0_lone_tick, s0_bad_act;
    int s7_hs_low, s7_vs_low, s7_tick7;

    // Every cycle: compare all instances against the model, and gather window statistics.
    always @(negedge clk) begin
        check_out("run_full", f_o, model(cyc, CFG_F));
        check_out("run_small0", s0_o, model(cyc, CFG_S0));
        check_out("run_small7", s7_o, model(cyc, CFG_S7));
        if (!rst_n) begin
            f_hs_low = 0; f_ls_n = 0; f_act_n = 0; f_bad_act = 0;
            s0_act_n = 0; s0_vs_low = 0; s0_tick7 = 0; s0_vb7 = 0;
            s0_tick2 = 0; s0_tick3 = 0; s0_lone_tick = 0; s0_bad_act = 0;
            s7_hs_low = 0; s7_vs_low = 0; s7_tick7 = 0;
        end else begin
            if (cyc >= 1 && cyc <= 800) begin
                if (!f_hs) f_hs_low++;
                if (f_ls)  f_ls_n++;
            end
            if (cyc <= 799 && f_act) f_act_n++;
            if (f_act && (int'(f_h) >= 640 || int'(f_v) >= 480)) f_bad_act++;
            if (cyc < SFT) begin
                if (s0_act) s0_act_n++;
                if (!s0_vs) s0_vs_low++;
            end
            if (cyc >= 1 && cyc <= 7 * SFT) begin
                if (s0_gt) s0_tick7++;
                if (s0_vb) s0_vb7++;
                if (s7_gt) s7_tick7++;
            end
            if (cyc >= 1 && cyc <= 2 * SFT && s0_gt) s0_tick2++;
            if (cyc >= 1 && cyc <= 3 * SFT && s0_gt) s0_tick3++;
            if (s0_gt && !s0_vb) s0_lone_tick++;
            if (s0_act && (int'(s0_h) >= SHD || int'(s0_v) >= SVD)) s0_bad_act++;
            if (cyc >= SFT && cyc < 2 * SFT) begin
                if (!s7_hs) s7_hs_low++;
                if (!s7_vs) s7_vs_low++;
            end
        end
    end

    task automatic check_counts(input string tag);
        wait_cyc(7 * SFT + 1);
        check_int({tag, "_full_hs_low_line0"}, f_hs_low, 96);
        check_int({tag, "_full_line_start_800"}, f_ls_n, 1);
        check_int({tag, "_full_active_line0"}, f_act_n, 640);
        check_int({tag, "_full_active_outside"}, f_bad_act, 0);
        check_int({tag, "_s0_active_frame"}, s0_act_n, SHD * SVD);
        check_int({tag, "_s0_vs_low_frame"}, s0_vs_low, SVS * SHT);
        check_int({tag, "_s0_vblanks_7f"}, s0_vb7, 7);
        check_int({tag, "_s0_ticks_7f"}, s0_tick7, 2);
        check_int({tag, "_s0_ticks_2f"}, s0_tick2, 0);
        check_int({tag, "_s0_ticks_3f"}, s0_tick3, 1);
        check_int({tag, "_s0_tick_without_vblank"}, s0_lone_tick, 0);
        check_int({tag, "_s0_active_outside"}, s0_bad_act, 0);
        check_int({tag, "_s7_hs_low_frame"}, s7_hs_low, SHS * SVT);
        check_int({tag, "_s7_vs_low_frame"}, s7_vs_low, SVS * SHT);
        check_int({tag, "_s7_ticks_7f"}, s7_tick7, 3);
    endtask

    task automatic check_reset_now(input string tag);
        check_out({tag, "_full"}, f_o, model(0, CFG_F));
        check_out({tag, "_small0"}, s0_o, model(0, CFG_S0));
        check_out({tag, "_small7"}, s7_o, model(0, CFG_S7));
    endtask

    vec_t vq[$];

    initial begin
        // t, sel(0 full,1 small0), h, v, act, hs, vs, ls, vb, gt -- ascending t
        vq.push_back('{0,    0, 0,   0,  1, 1, 1, 0, 0, 0});
        vq.push_back('{1,    0, 1,   0,  1, 1, 1, 0, 0, 0});
        vq.push_back('{23,   1, 23,  0,  0, 1, 1, 0, 0, 0});
        vq.push_back('{24,   1, 24,  0,  0, 0, 1, 0, 0, 0});
        vq.push_back('{29,   1, 29,  0,  0, 0, 1, 0, 0, 0});
        vq.push_back('{30,   1, 30,  0,  0, 1, 1, 0, 0, 0});
        vq.push_back('{35,   1, 0,   1,  1, 1, 1, 1, 0, 0});
        vq.push_back('{420,  1, 0,   12, 0, 1, 1, 1, 1, 0});
        vq.push_back('{524,  1, 34,  14, 0, 1, 1, 0, 0, 0});
        vq.push_back('{525,  1, 0,   15, 0, 1, 0, 1, 0, 0});
        vq.push_back('{594,  1, 34,  16, 0, 1, 0, 0, 0, 0});
        vq.push_back('{595,  1, 0,   17, 0, 1, 1, 1, 0, 0});
        vq.push_back('{639,  0, 639, 0,  1, 1, 1, 0, 0, 0});
        vq.push_back('{640,  0, 640, 0,  0, 1, 1, 0, 0, 0});
        vq.push_back('{657,  0, 657, 0,  0, 1, 1, 0, 0, 0});
        vq.push_back('{658,  0, 658, 0,  0, 0, 1, 0, 0, 0});
        vq.push_back('{734,  1, 34,  20, 0, 1, 1, 0, 0, 0});
        vq.push_back('{735,  1, 0,   0,  1, 1, 1, 1, 0, 0});
        vq.push_back('{753,  0, 753, 0,  0, 0, 1, 0, 0, 0});
        vq.push_back('{754,  0, 754, 0,  0, 1, 1, 0, 0, 0});
        vq.push_back('{799,  0, 799, 0,  0, 1, 1, 0, 0, 0});
        vq.push_back('{800,  0, 0,   1,  1, 1, 1, 1, 0, 0});
        vq.push_back('{801,  0, 1,   1,  1, 1, 1, 0, 0, 0});
        vq.push_back('{1155, 1, 0,   12, 0, 1, 1, 1, 1, 0});
        vq.push_back('{1890, 1, 0,   12, 0, 1, 1, 1, 1, 1});

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_now("reset_hold");
        rst_n = 1'b1;

        foreach (vq[i]) begin
            out_t e;
            wait_cyc(vq[i].t);
            e = {vq[i].h, vq[i].v, vq[i].act, vq[i].hs, vq[i].vs, vq[i].ls, vq[i].vb, vq[i].gt};
            check_out($sformatf("vec%0d_t%0d", i, vq[i].t), (vq[i].sel == 0) ? f_o : s0_o, e);
        end
        check_counts("first");

        // Random asynchronous resets landing between clock edges, mid-line.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(40, 1500)) @(posedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1 check_reset_now($sformatf("async_rst%0d", k));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        check_counts("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
